result_uart_tx: RTL and testbench

Drains the 16-bit ln(V) results (8.8 fixed point) that the ADC processing stage pushes into the result FIFO, and serialises each word onto a UART line as a 3-byte frame. The frame is a sync byte, then the high byte, then the low byte. The block is the FIFO's only reader and sits between the FIFO read port and the board TX pin. It pops one word per frame and never pops while a frame is in flight.

---
 rtl/result_uart_tx_if.sv | 19 +
 rtl/result_uart_tx.sv | 139 +++++++++++++
 tb/tb_result_uart_tx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/result_uart_tx_if.sv
// Read port of the result FIFO as seen by the UART drain.
// master = the reader (this block), slave = the FIFO side.
interface result_uart_tx_if;
  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en
  );
endinterface

// File: rtl/result_uart_tx.sv
// Pops 16-bit ln(V) results from the result FIFO and sends each one
// as a 3-byte 8N1 UART frame: sync, high byte, low byte.
module result_uart_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  result_uart_tx_if.master fifo,
  output logic tx,
  output logic busy
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, START, DATA, STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   word_q, word_d;
  logic          tx_q, tx_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          bit_end;

  assign bit_end = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    word_d  = word_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (enable && !fifo.fifo_empty) begin
          state_d = READ;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      READ: state_d = LATCH;
      LATCH: begin
        // FIFO data is valid now; start bit goes out on this edge
        state_d = START;
        word_d  = fifo.fifo_dout;
        byte_d  = 2'd0;
        shift_d = SYNC_BYTE;
        tx_d    = 1'b0;
        cnt_d   = '0;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d  = '0;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd2) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            shift_d = (byte_q == 2'd0) ? word_q[15:8]
                                       : word_q[7:0];
            tx_d    = 1'b0;
            state_d = START;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx              = tx_q;
  assign busy            = busy_q;
  assign fifo.fifo_rd_en = rd_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx with a FIFO model and a
// mid-bit sampling UART receiver, CLKS_PER_BIT = 4.
module tb_result_uart_tx;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic tx, busy;

  result_uart_tx_if f ();

  result_uart_tx #(
    .CLKS_PER_BIT(C),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .fifo(f),
    .tx(tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [15:0] q[$];
  int   qn = 0;
  logic underflow = 1'b0;

  assign f.fifo_empty = (qn == 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (f.fifo_rd_en) begin
      if (qn == 0) underflow <= 1'b1;
      else begin
        f.fifo_dout <= q.pop_front();
        qn <= qn - 1;
      end
    end
  end

  int   rd_rises = 0;
  int   rd_wide = 0;
  int   rd_t[$];
  int   busy_fall_t = -1;
  logic rd_p = 1'b0;
  logic busy_p = 1'b0;

  always @(negedge clk) begin
    if (f.fifo_rd_en && !rd_p) begin
      rd_rises <= rd_rises + 1;
      rd_t.push_back(cyc);
    end
    if (f.fifo_rd_en && rd_p) rd_wide <= rd_wide + 1;
    if (!busy && busy_p) busy_fall_t <= cyc;
    rd_p   <= f.fifo_rd_en;
    busy_p <= busy;
  end

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic push(logic [15:0] w);
    q.push_back(w);
    qn = qn + 1;
  endtask

  task automatic recv_byte(output logic [7:0] b,
                           output int t);
    int k = 0;
    b = '0;
    do begin
      @(negedge clk);
      k++;
    end while (tx !== 1'b0 && k < 3000);
    t = cyc;
    @(negedge clk);
    check("start_bit", int'(tx), 0);
    if (k >= 3000) return;
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      b[i] = tx;
    end
    repeat (C) @(negedge clk);
    check("stop_bit", int'(tx), 1);
  endtask

  task automatic recv_frame(logic [15:0] w, bit drop,
                            output int t0);
    logic [7:0] b;
    int t;
    int k;
    recv_byte(b, t0);
    check("sync_byte", int'(b), 'hA5);
    if (drop) begin
      fork
        begin
          repeat (10) @(negedge clk);
          enable = 1'b0;
        end
      join_none
    end
    recv_byte(b, t);
    check("hi_byte", int'(b), int'(w[15:8]));
    check("gap_b0_b1", t - t0, 10 * C);
    recv_byte(b, t);
    check("lo_byte", int'(b), int'(w[7:0]));
    check("gap_b0_b2", t - t0, 20 * C);
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("frame_len", busy_fall_t - t0, 30 * C);
  endtask

  initial begin
    int t0, t1, bad, k, e_t;
    f.fifo_dout = '0;

    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(f.fifo_rd_en), 0);
    rst_n = 1'b1;
    @(negedge clk);

    push(16'h0596);
    enable = 1'b1;
    recv_frame(16'h0596, 1'b0, t0);
    check("f1_rd_pulses", rd_rises, 1);
    check("f1_rd_to_tx", t0 - rd_t[0], 2);
    check("f1_busy_end", int'(busy), 0);

    push(16'h0000);
    push(16'hFFFF);
    recv_frame(16'h0000, 1'b0, t0);
    recv_frame(16'hFFFF, 1'b0, t1);
    check("b2b_rd_pulses", rd_rises, 3);
    check("b2b_rd_spacing", rd_t[2] - rd_t[1], 30 * C + 3);
    check("b2b_tx_spacing", t1 - t0, 30 * C + 3);
    check("rd_one_cycle", rd_wide, 0);

    enable = 1'b0;
    push(16'h5AC3);
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 ||
          f.fifo_rd_en !== 1'b0) bad++;
    end
    check("disabled_quiet", bad, 0);
    check("disabled_no_rd", rd_rises, 3);
    enable = 1'b1;
    e_t = cyc;
    recv_frame(16'h5AC3, 1'b0, t0);
    check("enable_to_rd", rd_t[3] - e_t, 1);

    push(16'h1357);
    push(16'h2468);
    recv_frame(16'h1357, 1'b1, t0);
    repeat (300) @(negedge clk);
    check("drop_rd_pulses", rd_rises, 5);
    check("drop_left_word", qn, 1);
    check("drop_busy", int'(busy), 0);
    enable = 1'b1;
    recv_frame(16'h2468, 1'b0, t0);
    check("resume_rd_pulses", rd_rises, 6);

    push(16'h1234);
    push(16'hC3A0);
    k = 0;
    while (rd_rises == 6 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (59) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", int'(tx), 1);
    check("mid_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("mid_rst_rd", rd_rises, 7);
    rst_n = 1'b1;
    recv_frame(16'hC3A0, 1'b0, t0);
    check("post_rst_rd", rd_rises, 8);
    check("post_rst_left", qn, 0);

    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 ||
          f.fifo_rd_en !== 1'b0) bad++;
    end
    check("empty_quiet", bad, 0);
    check("empty_no_rd", rd_rises, 8);
    check("underflow", int'(underflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
